// File: rtl/vend_disp_pkg.sv
// Shared types and digit codes for the vending display formatter.
package vend_disp_pkg;

  localparam logic [3:0] DIG_DASH  = 4'hA;
  localparam logic [3:0] DIG_C     = 4'hC;
  localparam logic [3:0] DIG_BLANK = 4'hF;

  typedef enum logic [1:0] {
    ModeNum    = 2'b00,
    ModeDash   = 2'b01,
    ModeChange = 2'b10,
    ModeBlank  = 2'b11
  } disp_mode_t;

  typedef enum logic [1:0] {
    StIdle,
    StConv,
    StCommit
  } state_t;

endpackage

// File: rtl/vend_display_fmt_if.sv
// Request/result bundle between the display formatter and its client.
interface vend_display_fmt_if
  import vend_disp_pkg::*;
#(
  parameter int unsigned W = 14
) ();

  logic        load;
  disp_mode_t  mode;
  logic [W-1:0] value;
  logic        busy;
  logic        done;
  logic [15:0] display_output;

  modport master (
    output load, mode, value,
    input  busy, done, display_output
  );

  modport slave (
    input  load, mode, value,
    output busy, done, display_output
  );

endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble: W shift steps after start, last flags the final step.
module bin2bcd_seq #(
  parameter int unsigned W = 14
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] bin,
  output logic [15:0]  bcd,
  output logic         last
);

  localparam int unsigned CW = $clog2(W + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  sr_q, sr_d;
  logic [15:0]   bcd_q, bcd_d;
  logic [15:0]   adj;

  always_comb begin
    adj = bcd_q;
    for (int i = 0; i < 4; i++) begin
      if (adj[4*i +: 4] >= 4'd5) adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
    end
    cnt_d = cnt_q;
    sr_d  = sr_q;
    bcd_d = bcd_q;
    if (start) begin
      cnt_d = CW'(W);
      sr_d  = bin;
      bcd_d = '0;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
      sr_d  = sr_q << 1;
      bcd_d = (adj << 1) | 16'(sr_q[W-1]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      sr_q  <= '0;
      bcd_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      sr_q  <= sr_d;
      bcd_q <= bcd_d;
    end
  end

  assign bcd  = bcd_q;
  assign last = (cnt_q == CW'(1));

endmodule

// File: rtl/vend_display_fmt.sv
// Formats a tenths-of-a-dollar amount into four display digit codes.
// Define VEND_DISP_LZB_EN to enable leading-zero blanking.
module vend_display_fmt
  import vend_disp_pkg::*;
#(
  parameter int unsigned W    = 14,
  parameter int unsigned MAXV = 9999
) (
  input logic               clk,
  input logic               rst_n,
  vend_display_fmt_if.slave bus
);

  state_t      state_q, state_d;
  disp_mode_t  mode_q, mode_d;
  logic        err_q, err_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [15:0] disp_q, disp_d;
  logic [15:0] bcd, fmt;
  logic        in_range, start, last;

  always_comb begin
    in_range = (bus.mode == ModeNum) ? (32'(bus.value) <= MAXV) : (32'(bus.value) <= 32'd999);
    start    = (state_q == StIdle) && bus.load && in_range &&
               ((bus.mode == ModeNum) || (bus.mode == ModeChange));
  end

  bin2bcd_seq #(
    .W(W)
  ) u_conv (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .bin  (bus.value),
    .bcd  (bcd),
    .last (last)
  );

  always_comb begin
    fmt = {4{DIG_DASH}};
    unique case (mode_q)
      ModeNum: begin
        if (!err_q) begin
          fmt = bcd;
`ifdef VEND_DISP_LZB_EN
          if (bcd[15:12] == 4'd0) begin
            fmt[15:12] = DIG_BLANK;
            if (bcd[11:8] == 4'd0) fmt[11:8] = DIG_BLANK;
          end
`endif
        end
      end
      ModeChange: begin
        if (!err_q) begin
          fmt = {DIG_C, bcd[11:0]};
`ifdef VEND_DISP_LZB_EN
          if (bcd[11:8] == 4'd0) fmt[11:8] = DIG_BLANK;
`endif
        end
      end
      ModeDash:  fmt = {4{DIG_DASH}};
      ModeBlank: fmt = {4{DIG_BLANK}};
      default:   fmt = {4{DIG_DASH}};
    endcase
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    err_d   = err_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    disp_d  = disp_q;
    unique case (state_q)
      StIdle: begin
        if (bus.load) begin
          mode_d = bus.mode;
          err_d  = !in_range;
          if (start) begin
            state_d = StConv;
            busy_d  = 1'b1;
          end else begin
            state_d = StCommit;
          end
        end
      end
      StConv: if (last) state_d = StCommit;
      StCommit: begin
        // Only write point of the display, so partial digits never reach the driver.
        disp_d  = fmt;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      mode_q  <= ModeNum;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      disp_q  <= 16'hFFFF;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      disp_q  <= disp_d;
    end
  end

  assign bus.busy           = busy_q;
  assign bus.done           = done_q;
  assign bus.display_output = disp_q;

endmodule

// File: tb/tb_vend_display_fmt.sv
// Directed self-checking bench for vend_display_fmt.
module tb_vend_display_fmt;
  import vend_disp_pkg::*;

  localparam int unsigned W = 14;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  vend_display_fmt_if #(.W(W)) bus ();

  vend_display_fmt #(
    .W   (W),
    .MAXV(9999)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issues one load, then scrambles the inputs and waits (bounded) for done.
  task automatic do_op(input disp_mode_t m, input logic [W-1:0] v,
                       output int lat, output int busy_n, output logic held);
    logic [15:0] prev;
    @(negedge clk);
    prev     = bus.display_output;
    bus.load = 1'b1;
    bus.mode = m;
    bus.value = v;
    @(negedge clk);
    bus.load  = 1'b0;
    bus.mode  = ModeBlank;
    bus.value = ~v;
    lat    = 0;
    busy_n = 0;
    held   = 1'b1;
    if (bus.busy) busy_n++;
    while (lat < 40) begin
      @(negedge clk);
      lat++;
      if (bus.done) break;
      if (bus.busy) busy_n++;
      if (bus.display_output !== prev) held = 1'b0;
    end
  endtask

  task automatic run(input string tag, input disp_mode_t m, input logic [W-1:0] v,
                     input logic [15:0] exp, input int exp_lat, input int exp_busy);
    int   lat, bn;
    logic held;
    do_op(m, v, lat, bn, held);
    chk({tag, ".disp"}, bus.display_output, exp);
    chk({tag, ".lat"}, 16'(lat), 16'(exp_lat));
    chk({tag, ".busy_cycles"}, 16'(bn), 16'(exp_busy));
    if (exp_lat > 1) chk({tag, ".held"}, 16'(held), 16'd1);
    @(negedge clk);
    chk({tag, ".done_1cyc"}, 16'(bus.done), 16'd0);
  endtask

  initial begin
    int   n_done;
    logic held;
    bus.load  = 1'b0;
    bus.mode  = ModeNum;
    bus.value = '0;

    repeat (2) @(negedge clk);
    chk("rst.disp", bus.display_output, 16'hFFFF);
    chk("rst.busy", 16'(bus.busy), 16'd0);
    chk("rst.done", 16'(bus.done), 16'd0);
    rst_n = 1'b1;

    run("num1234", ModeNum, 14'd1234, 16'h1234, 15, 15);
`ifdef VEND_DISP_LZB_EN
    run("num45", ModeNum, 14'd45, 16'hFF45, 15, 15);
    run("num0", ModeNum, 14'd0, 16'hFF00, 15, 15);
    run("chg75", ModeChange, 14'd75, 16'hCF75, 15, 15);
`else
    run("num45", ModeNum, 14'd45, 16'h0045, 15, 15);
    run("num0", ModeNum, 14'd0, 16'h0000, 15, 15);
    run("chg75", ModeChange, 14'd75, 16'hC075, 15, 15);
`endif
    run("num10000", ModeNum, 14'd10000, 16'hAAAA, 1, 0);
    run("chg1000", ModeChange, 14'd1000, 16'hAAAA, 1, 0);
    run("dash", ModeDash, 14'd42, 16'hAAAA, 1, 0);
    run("blank", ModeBlank, 14'd42, 16'hFFFF, 1, 0);

    // Mid-conversion load must be dropped; value churns the whole time.
    @(negedge clk);
    bus.mode  = ModeNum;
    bus.value = 14'd1234;
    bus.load  = 1'b1;
    @(negedge clk);
    bus.load = 1'b0;
    n_done   = 0;
    held     = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      bus.value = 14'($urandom);
      if (c == 5) begin
        bus.load  = 1'b1;
        bus.value = 14'd5678;
      end
      @(negedge clk);
      bus.load = 1'b0;
      if (bus.done) n_done++;
      else if (n_done == 0 && bus.display_output !== 16'hFFFF) held = 1'b0;
    end
    chk("ignore.disp", bus.display_output, 16'h1234);
    chk("ignore.ndone", 16'(n_done), 16'd1);
    chk("ignore.held", 16'(held), 16'd1);

    run("num9999", ModeNum, 14'd9999, 16'h9999, 15, 15);
    run("chg999", ModeChange, 14'd999, 16'hC999, 15, 15);

    // Asynchronous reset in the middle of a conversion.
    @(negedge clk);
    bus.mode  = ModeNum;
    bus.value = 14'd4321;
    bus.load  = 1'b1;
    @(negedge clk);
    bus.load = 1'b0;
    repeat (4) @(negedge clk);
    chk("midrst.busy_before", 16'(bus.busy), 16'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst.disp", bus.display_output, 16'hFFFF);
    chk("midrst.busy", 16'(bus.busy), 16'd0);
    chk("midrst.done", 16'(bus.done), 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run("num9999_after_rst", ModeNum, 14'd9999, 16'h9999, 15, 15);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
